// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-granular round-robin arbiter for one FIFO write port, with a stall watchdog
module fifo_wr_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int TIMEOUT = 64,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_data,
  input  logic [N_REQ-1:0]       i_req_last,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]       o_fifo_wr_data,
  output logic                   o_fifo_wr_en,
  input  logic                   i_fifo_full,
  output logic [IDX_W-1:0]       o_grant_id,
  output logic                   o_busy,
  output logic                   o_timeout
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [IDX_W-1:0] rr, pick, nxt;
  logic [WD_W-1:0] wd;
  logic xfer;
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + (IDX_W+1)'(b);
    return (s >= (IDX_W+1)'(N_REQ)) ? IDX_W'(s - (IDX_W+1)'(N_REQ)) : IDX_W'(s);
  endfunction
  // Scan from farthest to nearest offset so the nearest valid requester at/after rr wins
  always_comb begin
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (i_req_valid[wrap_add(rr, i)]) pick = wrap_add(rr, i);
  end
  assign nxt = wrap_add(o_grant_id, 1);
  assign o_busy = state == BUSY;
  assign xfer = o_busy && i_req_valid[o_grant_id] && !i_fifo_full;
  assign o_fifo_wr_en = xfer;
  assign o_fifo_wr_data = o_busy ? i_req_data[o_grant_id*WIDTH +: WIDTH] : '0;
  assign o_req_ready = (o_busy && !i_fifo_full) ? {{(N_REQ-1){1'b0}}, 1'b1} << o_grant_id : '0;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      o_grant_id <= '0;
      rr <= '0;
      wd <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      if (state == IDLE) begin
        wd <= '0;
        if (|i_req_valid) begin
          state <= BUSY;
          o_grant_id <= pick;
        end
      end else if (xfer) begin
        wd <= '0;
        if (i_req_last[o_grant_id]) begin
          state <= IDLE;
          rr <= nxt;
        end
      end else if (!i_fifo_full) begin
        if (wd == WD_W'(TIMEOUT - 1)) begin
          state <= IDLE;
          rr <= nxt;
          wd <= '0;
          o_timeout <= 1'b1;
        end else wd <= wd + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter driving a 16-deep behavioural FIFO_RAM model
module tb_fifo_wr_arbiter;
  localparam int T = 64;
  logic tb_clk = 1'b0;
  logic rst_n;
  logic [3:0] v, l, rdy;
  logic [31:0] d;
  logic [7:0] wr_data;
  logic wr_en, full, busy, to;
  logic [1:0] gid;
  logic [7:0] mem [16];
  logic [3:0] wp = '0, rp = '0;
  logic [4:0] cnt = '0;
  logic rd;
  logic bad_rdy = 1'b0, bad_wr = 1'b0;
  int to_cnt = 0, to_before;
  int tests = 0, fails = 0;
  logic [7:0] base, other;

  always #5 tb_clk = ~tb_clk;

  fifo_wr_arbiter #(.WIDTH(8), .N_REQ(4), .TIMEOUT(T)) dut (
    .i_clk(tb_clk), .i_rst(rst_n), .i_req_valid(v), .i_req_data(d), .i_req_last(l),
    .o_req_ready(rdy), .o_fifo_wr_data(wr_data), .o_fifo_wr_en(wr_en), .i_fifo_full(full),
    .o_grant_id(gid), .o_busy(busy), .o_timeout(to)
  );

  assign full = cnt == 5'd16;
  always @(posedge tb_clk) begin
    if (wr_en && !full) begin
      mem[wp] <= wr_data;
      wp <= wp + 4'd1;
    end
    if (rd && cnt != 0) rp <= rp + 4'd1;
    cnt <= cnt + 5'(wr_en && !full) - 5'(rd && cnt != 0);
  end

  always @(posedge tb_clk) if (to) to_cnt++;
  always begin
    @(negedge tb_clk);
    #2;
    if ($countones(rdy) > 1) bad_rdy = 1'b1;
    if (wr_en && full) bad_wr = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: time %0t exceeded limit", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int k, input logic [7:0] x, input logic lst);
    int c = 0;
    logic took = 1'b0;
    v[k] = 1'b1;
    d[k*8 +: 8] = x;
    l[k] = lst;
    while (!took && c < 300) begin
      #1;
      took = rdy[k];
      if (took) check("grant", 32'(gid), k);
      @(negedge tb_clk);
      c++;
    end
    v[k] = 1'b0;
    l[k] = 1'b0;
    check("send_done", 32'(took), 1);
  endtask

  task automatic pkt2(input int k);
    send(k, 8'(k*16), 1'b0);
    send(k, 8'(k*16 + 1), 1'b1);
  endtask

  task automatic pkt3(input int k);
    for (int b = 0; b < 3; b++) begin
      repeat ($urandom_range(0, 3)) @(negedge tb_clk);
      send(k, 8'(8'h60 + k*16 + b), b == 2);
    end
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    check(tag, 32'(mem[rp]), 32'(exp));
    rd = 1'b1;
    @(negedge tb_clk);
    rd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; v = '0; d = '0; l = '0; rd = 1'b0;
    repeat (2) @(negedge tb_clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(rdy), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_timeout", 32'(to), 0);
    check("rst_gid", 32'(gid), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    // reset mid-packet from req0
    @(negedge tb_clk);
    rst_n = 1'b1;
    v[0] = 1'b1; d[7:0] = 8'hA0; l[0] = 1'b0;
    @(negedge tb_clk);
    #1;
    check("t1_busy", 32'(busy), 1);
    check("t1_ready", 32'(rdy), 32'h1);
    @(negedge tb_clk);
    d[7:0] = 8'hA1;
    rst_n = 1'b0;
    #1;
    check("t1_rst_busy", 32'(busy), 0);
    check("t1_rst_ready", 32'(rdy), 0);
    check("t1_rst_wr_en", 32'(wr_en), 0);
    check("t1_rst_wr_data", 32'(wr_data), 0);
    repeat (2) @(negedge tb_clk);
    rst_n = 1'b1;
    @(negedge tb_clk);
    #1;
    check("t1_regrant_busy", 32'(busy), 1);
    check("t1_regrant_gid", 32'(gid), 0);
    send(0, 8'hA1, 1'b1);
    #1;
    check("t1_cnt", 32'(cnt), 2);
    pop("t1_d0", 8'hA0);
    pop("t1_d1", 8'hA1);
    // single requester, 4-beat packet
    send(1, 8'h10, 1'b0);
    send(1, 8'h11, 1'b0);
    send(1, 8'h12, 1'b0);
    send(1, 8'h13, 1'b1);
    #1;
    check("t2_busy_drop", 32'(busy), 0);
    check("t2_cnt", 32'(cnt), 4);
    for (int i = 0; i < 4; i++) pop("t2_data", 8'(8'h10 + i));
    // round-robin with all four requesters from rr=0
    rst_n = 1'b0;
    @(negedge tb_clk);
    rst_n = 1'b1;
    fork
      pkt2(0);
      pkt2(1);
      pkt2(2);
      pkt2(3);
    join
    #1;
    check("t3_cnt", 32'(cnt), 8);
    for (int i = 0; i < 8; i++) pop("t3_order", 8'((i/2)*16 + i%2));
    fork
      send(2, 8'h2A, 1'b1);
      send(0, 8'h0A, 1'b1);
    join
    pop("t3_wrap0", 8'h0A);
    pop("t3_wrap1", 8'h2A);
    // full back-pressure
    to_before = to_cnt;
    fork
      for (int i = 0; i < 20; i++) send(2, 8'(i), i == 19);
      begin
        int c = 0;
        while (cnt != 16 && c < 100) begin
          @(negedge tb_clk);
          c++;
        end
        #1;
        check("t4_full", 32'(full), 1);
        check("t4_ready_low", 32'(rdy), 0);
        check("t4_wr_en_low", 32'(wr_en), 0);
        check("t4_busy_held", 32'(busy), 1);
        repeat (3) @(negedge tb_clk);
        #1;
        check("t4_ready_low2", 32'(rdy), 0);
        check("t4_gid_held", 32'(gid), 2);
        check("t4_cnt_hold", 32'(cnt), 16);
        for (int i = 0; i < 4; i++) pop("t4_drain", 8'(i));
      end
    join
    #1;
    check("t4_cnt", 32'(cnt), 16);
    for (int i = 4; i < 20; i++) pop("t4_data", 8'(i));
    check("t4_no_timeout", 32'(to_cnt), 32'(to_before));
    // watchdog
    to_before = to_cnt;
    send(0, 8'h50, 1'b0);
    send(0, 8'h51, 1'b0);
    v[3] = 1'b1; d[31:24] = 8'h3C; l[3] = 1'b1;
    repeat (T - 1) @(negedge tb_clk);
    #1;
    check("t5_to_early", 32'(to), 0);
    check("t5_busy_early", 32'(busy), 1);
    @(negedge tb_clk);
    #1;
    check("t5_to_pulse", 32'(to), 1);
    check("t5_busy_off", 32'(busy), 0);
    v[0] = 1'b1; d[7:0] = 8'h52; l[0] = 1'b1;
    @(negedge tb_clk);
    #1;
    check("t5_to_once", 32'(to), 0);
    check("t5_busy_next", 32'(busy), 1);
    check("t5_gid_req3", 32'(gid), 3);
    send(3, 8'h3C, 1'b1);
    send(0, 8'h52, 1'b1);
    #1;
    check("t5_cnt", 32'(cnt), 4);
    pop("t5_d0", 8'h50);
    pop("t5_d1", 8'h51);
    pop("t5_d2", 8'h3C);
    pop("t5_d3", 8'h52);
    check("t5_to_count", 32'(to_cnt), 32'(to_before + 1));
    // contiguity under random gaps
    fork
      pkt3(0);
      pkt3(1);
    join
    #1;
    check("t6_cnt", 32'(cnt), 6);
    base = mem[rp];
    check("t6_first", 32'(base == 8'h60 || base == 8'h70), 1);
    other = (base == 8'h60) ? 8'h70 : 8'h60;
    for (int i = 0; i < 3; i++) pop("t6_pkt_a", 8'(base + i));
    for (int i = 0; i < 3; i++) pop("t6_pkt_b", 8'(other + i));
    check("onehot_ready", 32'(bad_rdy), 0);
    check("wr_when_full", 32'(bad_wr), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
